// File: rtl/xilinx_fifo_a1.sv
// Single-clock first-word-fall-through FIFO with registered full/empty flags
// and occupancy counts; depth follows block-RAM aspect ratios for the width.
module xilinx_fifo_a1 #(
    parameter int DSIZE = 8,
    parameter int LSIZE = (DSIZE >= 19) ? 9 :
                          (DSIZE >= 10) ? 10 :
                          (DSIZE >= 5)  ? 11 : 12
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic [DSIZE-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [DSIZE-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LSIZE-1:0] wcount,
    output logic [LSIZE-1:0] rcount
);

    localparam int DEPTH = 1 << LSIZE;

    logic [DSIZE-1:0] mem_q [DEPTH];
    logic [LSIZE-1:0] wptr_q, wptr_d;
    logic [LSIZE-1:0] rptr_q, rptr_d;
    logic [LSIZE:0]   occ_q, occ_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             wr_ok, rd_ok;

    // Handshake: a write is taken when wr_en is high and full is low; a read
    // (pop of dout) is taken when rd_en is high and empty is low. Refused
    // requests are silently dropped. Flags come from registers, so a read in
    // the same cycle never frees room for a write while full, and a write
    // never makes a read legal while empty.
    assign wr_ok = wr_en & ~full_q;
    assign rd_ok = rd_en & ~empty_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (wr_ok) wptr_d = wptr_q + LSIZE'(1);
        if (rd_ok) rptr_d = rptr_q + LSIZE'(1);
        case ({wr_ok, rd_ok})
            2'b10:   occ_d = occ_q + (LSIZE+1)'(1);
            2'b01:   occ_d = occ_q - (LSIZE+1)'(1);
            default: occ_d = occ_q;
        endcase
        full_d  = (occ_d == (LSIZE+1)'(DEPTH));
        empty_d = (occ_d == '0);
    end

    always_ff @(posedge clock) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            occ_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            occ_q   <= occ_d;
            full_q  <= full_d;
            empty_q <= empty_d;
        end
    end

    // Storage is deliberately not reset so it can map onto RAM primitives.
    always_ff @(posedge clock) begin
        if (rst_n && wr_ok) mem_q[wptr_q] <= din;
    end

    assign dout   = mem_q[rptr_q];
    assign full   = full_q;
    assign empty  = empty_q;
    assign wcount = occ_q[LSIZE-1:0];
    assign rcount = occ_q[LSIZE-1:0];

endmodule

// File: tb/tb_xilinx_fifo_a1.sv
// Directed bench for xilinx_fifo_a1 (DSIZE=40, 512 words): a vector table for
// the short cases plus model-checked sequences for fill, streaming, wrap, reset.
module tb_xilinx_fifo_a1;

  localparam int DW    = 40;
  localparam int LW    = 9;
  localparam int DEPTH = 512;

  logic          clock;
  logic          rst_n;
  logic [DW-1:0] din;
  logic          wr_en;
  logic          rd_en;
  logic [DW-1:0] dout;
  logic          full;
  logic          empty;
  logic [LW-1:0] wcount;
  logic [LW-1:0] rcount;

  xilinx_fifo_a1 #(.DSIZE(DW)) dut (
    .clock  (clock),
    .rst_n  (rst_n),
    .din    (din),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .dout   (dout),
    .full   (full),
    .empty  (empty),
    .wcount (wcount),
    .rcount (rcount)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // scoreboard: reference queue and occupancy
  logic [DW-1:0] exp_q[$];
  int            model_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  typedef struct {
    logic          rst_n;
    logic          wr;
    logic          rd;
    logic [DW-1:0] din;
    logic          e_empty;
    logic          e_full;
    logic [LW-1:0] e_cnt;
    logic          chk_dout;
    logic [DW-1:0] e_dout;
  } vec_t;

  function automatic vec_t mk(logic r, logic w, logic rd, logic [DW-1:0] d,
                              logic e, logic f, logic [LW-1:0] c,
                              logic cd, logic [DW-1:0] ed);
    vec_t v;
    v.rst_n = r; v.wr = w; v.rd = rd; v.din = d;
    v.e_empty = e; v.e_full = f; v.e_cnt = c; v.chk_dout = cd; v.e_dout = ed;
    return v;
  endfunction

  // driver: apply inputs, clock once, sample 1 time unit after the edge
  task automatic step(input logic r, input logic w, input logic rd, input logic [DW-1:0] d);
    rst_n = r; wr_en = w; rd_en = rd; din = d;
    @(posedge clock);
    #1;
  endtask

  // driver plus reference model; checks all outputs after the edge
  task automatic mcycle(input logic w, input logic rd, input logic [DW-1:0] d, input string tag);
    bit wa, ra;
    wa = w && (model_cnt < DEPTH);
    ra = rd && (model_cnt > 0);
    step(1'b1, w, rd, d);
    if (ra) begin void'(exp_q.pop_front()); model_cnt--; end
    if (wa) begin exp_q.push_back(d); model_cnt++; end
    check({tag, ".empty"}, 64'(empty), 64'(model_cnt == 0));
    check({tag, ".full"}, 64'(full), 64'(model_cnt == DEPTH));
    check({tag, ".wcount"}, 64'(wcount), 64'(model_cnt % DEPTH));
    check({tag, ".rcount"}, 64'(rcount), 64'(model_cnt % DEPTH));
    if (model_cnt > 0) check({tag, ".dout"}, 64'(dout), 64'(exp_q[0]));
  endtask

  task automatic model_reset();
    step(1'b0, 1'b0, 1'b0, '0);
    exp_q.delete();
    model_cnt = 0;
  endtask

  vec_t vecs[13];

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    //               rst wr rd din      empty full cnt chk dout
    vecs[0]  = mk(0, 0, 0, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[1]  = mk(0, 0, 0, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[2]  = mk(0, 0, 0, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[3]  = mk(1, 0, 1, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[4]  = mk(1, 1, 0, 40'hA5, 0, 0, 9'd1, 1, 40'hA5);
    vecs[5]  = mk(1, 0, 0, 40'h0,  0, 0, 9'd1, 1, 40'hA5);
    vecs[6]  = mk(1, 0, 1, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[7]  = mk(1, 1, 1, 40'h11, 0, 0, 9'd1, 1, 40'h11);
    vecs[8]  = mk(1, 1, 0, 40'h22, 0, 0, 9'd2, 1, 40'h11);
    vecs[9]  = mk(1, 1, 1, 40'h33, 0, 0, 9'd2, 1, 40'h22);
    vecs[10] = mk(1, 0, 1, 40'h0,  0, 0, 9'd1, 1, 40'h33);
    vecs[11] = mk(1, 0, 1, 40'h0,  1, 0, 9'd0, 0, 40'h0);
    vecs[12] = mk(1, 0, 1, 40'h0,  1, 0, 9'd0, 0, 40'h0);

    for (int i = 0; i < 13; i++) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d.empty", i), 64'(empty), 64'(vecs[i].e_empty));
      check($sformatf("vec%0d.full", i), 64'(full), 64'(vecs[i].e_full));
      check($sformatf("vec%0d.wcount", i), 64'(wcount), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d.rcount", i), 64'(rcount), 64'(vecs[i].e_cnt));
      if (vecs[i].chk_dout)
        check($sformatf("vec%0d.dout", i), 64'(dout), 64'(vecs[i].e_dout));
    end

    // fill to DEPTH, overflow write, then full with simultaneous wr+rd
    model_reset();
    for (int i = 0; i < DEPTH; i++) mcycle(1'b1, 1'b0, DW'(i), "fill");
    check("fill.full_at_512", 64'(full), 64'd1);
    check("fill.wcount_wraps", 64'(wcount), 64'd0);
    mcycle(1'b1, 1'b0, DW'(999), "overflow");
    check("overflow.head", 64'(dout), 64'd0);
    mcycle(1'b1, 1'b1, DW'(777), "full_wr_rd");
    check("full_wr_rd.full_drops", 64'(full), 64'd0);
    check("full_wr_rd.wcount", 64'(wcount), 64'd511);
    check("full_wr_rd.head", 64'(dout), 64'd1);
    while (model_cnt > 1) mcycle(1'b0, 1'b1, '0, "drain");
    check("drain.last_word", 64'(dout), 64'd511);
    mcycle(1'b0, 1'b1, '0, "drain_last");
    check("drain.empty_after", 64'(empty), 64'd1);

    // empty with wr+rd: only the write lands
    mcycle(1'b1, 1'b1, DW'(40'h5A5A), "empty_wr_rd");
    check("empty_wr_rd.dout", 64'(dout), 64'h5A5A);
    mcycle(1'b0, 1'b1, '0, "empty_wr_rd_pop");

    // streaming: 5 queued, 100 cycles of simultaneous wr+rd
    for (int i = 0; i < 5; i++) mcycle(1'b1, 1'b0, DW'(40'h100 + i), "prime");
    for (int i = 0; i < 100; i++) mcycle(1'b1, 1'b1, DW'(40'h200 + i), "stream");
    check("stream.wcount_5", 64'(wcount), 64'd5);
    check("stream.head", 64'(dout), 64'h25F);
    while (model_cnt > 0) mcycle(1'b0, 1'b1, '0, "stream_drain");

    // wrap-around: fill 300 / drain 300, five rounds
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 300; i++) mcycle(1'b1, 1'b0, {8'(r), 32'(i ^ 32'hA5A5)}, "wrap_fill");
      check("wrap.count300", 64'(wcount), 64'd300);
      while (model_cnt > 0) mcycle(1'b0, 1'b1, '0, "wrap_drain");
    end

    // mid-operation reset with 200 words stored
    for (int i = 0; i < 200; i++) mcycle(1'b1, 1'b0, DW'(40'h7000 + i), "pre_rst");
    model_reset();
    check("midrst.empty", 64'(empty), 64'd1);
    check("midrst.full", 64'(full), 64'd0);
    check("midrst.wcount", 64'(wcount), 64'd0);
    check("midrst.rcount", 64'(rcount), 64'd0);
    mcycle(1'b1, 1'b0, DW'(40'h3C), "post_rst");
    check("post_rst.dout", 64'(dout), 64'h3C);
    check("post_rst.empty", 64'(empty), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xilinx_fifo_a1.md
Name: xilinx_fifo_a1

Overview:
Single-clock, first-word-fall-through (FWFT) data FIFO with full/empty flags and occupancy counts. It is the native data store behind the AXI-stream packet FIFO. The upstream side writes on wr_en. The downstream side sees the head word on dout whenever empty is low, and pops it with rd_en. Depth is a power of two derived from the data width, matching block-RAM aspect ratios.

Parameters:
DSIZE, 8, data width in bits (min 1).
LSIZE, derived from DSIZE, log2 of depth:
- DSIZE>=19 → 9 (512 words)
- 10..18 → 10 (1024 words)
- 5..9 → 11 (2048 words)
- 1..4 → 12 (4096 words)
- Overridable; DEPTH = 2**LSIZE.

Ports:
clock  input  1  single clock; all logic updates on rising edge
rst_n  input  1  synchronous active-low reset
din  input  DSIZE  write data
wr_en  input  1  write request
rd_en  input  1  read/pop request (acknowledges current dout)
dout  output  DSIZE  head-of-queue word (FWFT)
full  output  1  FIFO holds DEPTH words
empty  output  1  FIFO holds 0 words
wcount  output  LSIZE  occupancy, low LSIZE bits (write-side view)
rcount  output  LSIZE  occupancy, low LSIZE bits (read-side view; identical to wcount in this single-clock block)

Behaviour:
- Storage: DEPTH x DSIZE memory; LSIZE-bit write and read pointers wrap modulo DEPTH; internal occupancy counter is LSIZE+1 bits.
- Reset (rst_n low at clock edge): pointers=0, occupancy=0, empty=1, full=0, wcount=rcount=0. Memory contents are not cleared. Reset mid-operation discards all stored words.
- Write accepted iff wr_en && !full: mem[wptr]<=din, wptr++.
- Read accepted iff rd_en && !empty: rptr++.
- Ignored requests: wr_en while full and rd_en while empty are ignored, with no state change and no error flag.
- Simultaneous accepted write+read: occupancy unchanged and both pointers advance.
- When full, a write is refused even if rd_en is high in the same cycle; only the read happens.
- When empty, rd_en is ignored even if wr_en is high in the same cycle; only the write happens.
- Flag and count registers: empty, full and occupancy are registered and updated on the same edge as the pointers.
  - empty=1 iff occupancy==0.
  - full=1 iff occupancy==DEPTH.
  - wcount=rcount=occupancy[LSIZE-1:0], so they read 0 when full; consumers disambiguate with full.
- FWFT read path: dout = mem[rptr] (asynchronous/distributed read of the head).
  - A word written at edge N is visible on dout, with empty=0, after edge N when the FIFO was empty.
  - dout changes to the next word on the edge that accepts a read.
  - dout is don't-care while empty=1.
- Ordering: strict FIFO. Data is never duplicated, dropped or reordered except by reset.
- Latency: write-to-output 1 cycle. full asserts on the edge that stores the DEPTH-th word and deasserts on the edge accepting the next read.

Test Plan:
- Reset (DSIZE=40, LSIZE=9): hold rst_n low 3 cycles → empty=1, full=0, wcount=rcount=0. Assert rd_en with rst_n high → no change.
- Single word: write din=0xA5 one cycle → next cycle empty=0, dout=0xA5, wcount=1. Pulse rd_en → empty=1, wcount=0.
- Fill (DSIZE=40): write 512 incrementing words 0..511 with no reads → full=1, wcount=0.
  - A 513th write with din=999 is dropped.
  - Draining yields exactly 0..511 in order; empty=1 after the last read.
- Simultaneous traffic: with 5 words queued, assert wr_en and rd_en together for 100 cycles → wcount stays 5 and output sequence order is preserved.
  - At full, wr_en+rd_en → only the read is accepted; full drops to 0.
  - At empty, wr_en+rd_en → only the write is accepted; empty drops to 0.
- Wrap-around: repeatedly fill to 300 words and drain, 5 rounds → pointers wrap and no data corruption across the 511→0 boundary.
- Mid-operation reset: with 200 words stored, pulse rst_n low one cycle → empty=1, count=0. A subsequent write of 0x3C appears on dout next cycle.
